// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x fractional-accumulator oversampling.
// Bits are sampled at mid-period. Received bytes are handed out as single-cycle
// strobes (data_valid / frame_error).
// Optional feature macro: UART_RX_MAJORITY_EN. When it is defined, each bit is
// the 2-of-3 majority of the samples taken at the last three ticks up to and
// including the evaluation point.
module uart_rx #(
    parameter int unsigned freq_in       = 50000000,
    parameter int unsigned freq_out      = 57600,
    parameter int unsigned acc_precision = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    // Rounded 16x baud rate, scaled by 2^acc_precision, relative to freq_in.
    localparam logic [63:0] INC_WIDE =
        ((64'(freq_out) << (acc_precision + 4)) + 64'(freq_in / 2)) / 64'(freq_in);
    localparam logic [acc_precision:0] INCREMENT = INC_WIDE[acc_precision:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic                   sync1;
    logic                   rx;
    logic [acc_precision:0] acc;
    logic                   tick;
    logic                   bit_val;

    state_t     state, state_n;
    logic [3:0] os_cnt, os_cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_out_n;
    logic       valid_n;
    logic       ferr_n;

    // Two-flop synchronizer; idle level is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= uart_in;
            rx    <= sync1;
        end
    end

    // Free-running phase accumulator; its carry bit is the oversample tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[acc_precision-1:0]} + INCREMENT;
        end
    end

    assign tick = acc[acc_precision];

`ifdef UART_RX_MAJORITY_EN
    // samp[0] holds the previous tick's sample and samp[1] the one before it.
    logic [1:0] samp;

    // Keep the last two tick samples of the line for majority voting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp <= '1;
        end else if (tick) begin
            samp <= {samp[0], rx};
        end
    end

    assign bit_val = (samp[1] & samp[0]) | (samp[1] & rx) | (samp[0] & rx);
`else
    assign bit_val = rx;
`endif

    // State and datapath registers; busy is a registered copy of the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            os_cnt      <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            os_cnt      <= os_cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            data_out    <= data_out_n;
            data_valid  <= valid_n;
            frame_error <= ferr_n;
            busy        <= (state_n != ST_IDLE);
        end
    end

    // Next-state and strobe logic; every transition is qualified by a tick.
    always_comb begin
        state_n    = state;
        os_cnt_n   = os_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        data_out_n = data_out;
        valid_n    = 1'b0;
        ferr_n     = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state_n  = ST_START;
                        os_cnt_n = '0;
                    end
                end
                ST_START: begin
                    os_cnt_n = os_cnt + 4'd1;
                    if (os_cnt == 4'd7) begin
                        if (!bit_val) begin
                            state_n   = ST_DATA;
                            os_cnt_n  = '0;
                            bit_idx_n = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    os_cnt_n = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        shift_n = {bit_val, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_n = ST_STOP;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    os_cnt_n = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        if (bit_val) begin
                            data_out_n = shift;
                            valid_n    = 1'b1;
                            state_n    = ST_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives 8N1 frames on the serial line, keeps a queue of
// expected bytes and compares each received byte as the DUT strobes it out.
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int n_asserts = 0;
    int n_fail    = 0;

    localparam int CPB = 868;

    uart_rx #(
        .freq_in(50000000),
        .freq_out(57600),
        .acc_precision(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .uart_in(uart_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Scoreboard queues: expected bytes (pushed with stimulus) and received bytes.
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] last_good = 8'h00;

    int         fe_cnt      = 0;
    int         both_cnt    = 0;
    int         width_bad   = 0;
    int         dout_glitch = 0;
    logic       prev_valid  = 1'b0;
    logic       prev_fe     = 1'b0;
    logic [7:0] prev_dout   = 8'h00;

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_fe    = 1'b0;
            prev_dout  = data_out;
        end else begin
            if (data_valid) begin
                rx_q.push_back(data_out);
                rx_t.push_back(cyc);
            end
            if (frame_error) fe_cnt++;
            if (data_valid && frame_error) both_cnt++;
            if ((data_valid && prev_valid) || (frame_error && prev_fe)) width_bad++;
            if (!data_valid && data_out !== prev_dout) dout_glitch++;
            prev_valid = data_valid;
            prev_fe    = frame_error;
            prev_dout  = data_out;
        end
    end

    task automatic hold_line(input logic v, input int clocks);
        uart_in = v;
        repeat (clocks) @(posedge clock);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
        hold_line(1'b0, cpb);
        for (int i = 0; i < 8; i++) hold_line(b[i], cpb);
        hold_line(stop_bit, cpb);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clock);
            #2;
            k++;
        end
    endtask

    task automatic test_reset;
        repeat (5) @(posedge clock);
        #2;
        n_asserts++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_asserts++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        n_asserts++;
        if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        n_asserts++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        hold_line(1'b1, 300);
    endtask

    task automatic test_single;
        logic [7:0] exp;
        logic [7:0] got;
        int fe0 = fe_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, CPB, 1'b1);
        wait_rx(1, 500);
        hold_line(1'b1, 300);
        exp = exp_q.pop_front();
        n_asserts++;
        if (rx_q.size() == 0) begin
            n_fail++; $display("FAIL single_value: no data_valid, expected %h", exp);
        end else begin
            got = rx_q.pop_front();
            void'(rx_t.pop_front());
            if (got !== exp) begin n_fail++; $display("FAIL single_value: got %h expected %h", got, exp); end
            else last_good = exp;
        end
        n_asserts++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL single_count: %0d extra strobes, expected 0", rx_q.size()); rx_q.delete(); rx_t.delete(); end
        n_asserts++;
        if (fe_cnt != fe0) begin n_fail++; $display("FAIL single_ferr: got %0d frame errors expected 0", fe_cnt - fe0); end
        n_asserts++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        logic [7:0] got;
        int t0 = 0;
        int t1 = 0;
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, CPB, 1'b1);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, CPB, 1'b1);
        wait_rx(2, 500);
        hold_line(1'b1, 300);
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            n_asserts++;
            if (rx_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_value%0d: no data_valid, expected %h", i, exp);
            end else begin
                got = rx_q.pop_front();
                if (i == 0) t0 = rx_t.pop_front(); else t1 = rx_t.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL b2b_value%0d: got %h expected %h", i, got, exp); end
                else last_good = exp;
            end
        end
        n_asserts++;
        if (t1 - t0 < 10 * CPB - 120 || t1 - t0 > 10 * CPB + 120) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d clocks expected %0d +/-120", t1 - t0, 10 * CPB);
        end
    endtask

    task automatic test_glitch(input int len, input logic expect_busy);
        int   fe0 = fe_cnt;
        logic busy_seen = 1'b0;
        uart_in = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(posedge clock); #2;
            if (busy) busy_seen = 1'b1;
        end
        uart_in = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #2;
            if (busy) busy_seen = 1'b1;
        end
        n_asserts++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL glitch%0d_valid: got %0d strobes expected 0", len, rx_q.size()); rx_q.delete(); rx_t.delete(); end
        n_asserts++;
        if (fe_cnt != fe0) begin n_fail++; $display("FAIL glitch%0d_ferr: got %0d frame errors expected 0", len, fe_cnt - fe0); end
        n_asserts++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch%0d_busy_end: got %b expected 0", len, busy); end
        if (expect_busy) begin
            n_asserts++;
            if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch%0d_busy_seen: got %b expected 1", len, busy_seen); end
        end
    endtask

    task automatic test_frame_error;
        logic [7:0] exp;
        logic [7:0] got;
        int fe0 = fe_cnt;
        send_byte(8'h81, CPB, 1'b0);
        hold_line(1'b0, 3000);
        n_asserts++;
        if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d frame errors expected 1", fe_cnt - fe0); end
        n_asserts++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d strobes expected 0", rx_q.size()); rx_q.delete(); rx_t.delete(); end
        n_asserts++;
        if (data_out !== last_good) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected %h", data_out, last_good); end
        n_asserts++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
        hold_line(1'b1, 500);
        n_asserts++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit: got busy %b expected 0", busy); end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, CPB, 1'b1);
        wait_rx(1, 500);
        hold_line(1'b1, 300);
        exp = exp_q.pop_front();
        n_asserts++;
        if (rx_q.size() == 0) begin
            n_fail++; $display("FAIL ferr_next_value: no data_valid, expected %h", exp);
        end else begin
            got = rx_q.pop_front();
            void'(rx_t.pop_front());
            if (got !== exp) begin n_fail++; $display("FAIL ferr_next_value: got %h expected %h", got, exp); end
            else last_good = exp;
        end
        n_asserts++;
        if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL ferr_next_ferr: got %0d frame errors expected 1", fe_cnt - fe0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp;
        logic [7:0] got;
        int fe0 = fe_cnt;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold_line(1'b1, CPB);
        hold_line(1'b1, 400);
        reset = 1'b1;
        #1;
        n_asserts++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_asserts++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 00", data_out); end
        n_asserts++;
        if (data_valid !== 1'b0 || frame_error !== 1'b0) begin
            n_fail++; $display("FAIL midrst_strobes: got valid %b ferr %b expected 0 0", data_valid, frame_error);
        end
        last_good = 8'h00;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        hold_line(1'b1, 468 + 4 * CPB);
        n_asserts++;
        if (rx_q.size() != 0 || fe_cnt != fe0) begin
            n_fail++; $display("FAIL midrst_no_strobe: got %0d valid %0d ferr expected 0 0", rx_q.size(), fe_cnt - fe0);
            rx_q.delete(); rx_t.delete();
        end
        exp_q.push_back(8'h42);
        send_byte(8'h42, CPB, 1'b1);
        wait_rx(1, 500);
        hold_line(1'b1, 300);
        exp = exp_q.pop_front();
        n_asserts++;
        if (rx_q.size() == 0) begin
            n_fail++; $display("FAIL midrst_next_value: no data_valid, expected %h", exp);
        end else begin
            got = rx_q.pop_front();
            void'(rx_t.pop_front());
            if (got !== exp) begin n_fail++; $display("FAIL midrst_next_value: got %h expected %h", got, exp); end
            else last_good = exp;
        end
    endtask

    task automatic test_baud_tolerance;
        logic [7:0] exp;
        logic [7:0] got;
        int fe0 = fe_cnt;
        int rates[2] = '{851, 885};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'hC6);
            send_byte(8'hC6, rates[r], 1'b1);
            wait_rx(1, 500);
            hold_line(1'b1, 300);
            exp = exp_q.pop_front();
            n_asserts++;
            if (rx_q.size() == 0) begin
                n_fail++; $display("FAIL baud%0d_value: no data_valid, expected %h", rates[r], exp);
            end else begin
                got = rx_q.pop_front();
                void'(rx_t.pop_front());
                if (got !== exp) begin n_fail++; $display("FAIL baud%0d_value: got %h expected %h", rates[r], got, exp); end
                else last_good = exp;
            end
        end
        n_asserts++;
        if (fe_cnt != fe0) begin n_fail++; $display("FAIL baud_ferr: got %0d frame errors expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_invariants;
        n_asserts++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL both_strobes: got %0d cycles expected 0", both_cnt); end
        n_asserts++;
        if (width_bad != 0) begin n_fail++; $display("FAIL strobe_width: got %0d long strobes expected 0", width_bad); end
        n_asserts++;
        if (dout_glitch != 0) begin n_fail++; $display("FAIL data_out_stable: got %0d changes without strobe expected 0", dout_glitch); end
        n_asserts++;
        if (data_out !== last_good) begin n_fail++; $display("FAIL final_data_out: got %h expected %h", data_out, last_good); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch(200, 1'b1);
        test_glitch(60, 1'b0);
        test_frame_error();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
